// File: rtl/adder32_pkg.sv
// Shared definitions for the digit-serial 32-bit arithmetic slices.
//   WIDTH       operand/result width
//   DIGIT_W     bits handled per cycle (one adder32 partition wide)
//   NUM_DIGITS  digits needed to cover WIDTH bits
//   digit_idx_t digit counter type
//   sub_state_t sequencing states of the subtractor
package adder32_pkg;

    localparam int WIDTH      = 32;
    localparam int DIGIT_W    = 3;
    localparam int NUM_DIGITS = (WIDTH + DIGIT_W - 1) / DIGIT_W;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [IDX_W-1:0] digit_idx_t;

    localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/digit_add3.sv
// Combinational 3-bit ripple adder, one digit of the digit-serial datapath.
//   x, y  digit operands
//   cin   carry into bit 0
//   s     3-bit sum
//   cout  carry out of bit 2
module digit_add3 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       cin,
    output logic [2:0] s,
    output logic       cout
);

    logic [3:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 3; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = c[3];

endmodule

// File: rtl/sub32_digit_serial.sv
// Digit-serial 32-bit subtractor: diff = a - b, three bits per cycle.
// Implemented as a + ~b + 1 through a single time-multiplexed 3-bit adder.
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_ready   operand handshake (a, b)
//   out_valid, out_ready result handshake (diff, borrow, overflow)
//   borrow               a < b as unsigned
//   overflow             signed overflow of a - b
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per cycle, k = digit being processed
// DONE  | result held, out_valid high until out_ready
module sub32_digit_serial
    import adder32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    sub_state_t       state;
    digit_idx_t       k;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;
    // Sum digits 0..9 accumulate here; digit 10 is merged in at the final edge.
    logic [WIDTH-3:0] acc;

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   nb_ext;
    logic [2:0]       x_dig;
    logic [2:0]       y_dig;
    logic [2:0]       s_dig;
    logic             c_dig;

    // Bit 32 is zero in both operands, so for the top digit s[2] is the
    // carry out of bit 31.
    assign a_ext  = {1'b0, a_reg};
    assign nb_ext = {1'b0, nb_reg};
    assign x_dig  = 3'(a_ext  >> (DIGIT_W * int'(k)));
    assign y_dig  = 3'(nb_ext >> (DIGIT_W * int'(k)));

    digit_add3 u_digit (
        .x    (x_dig),
        .y    (y_dig),
        .cin  (carry),
        .s    (s_dig),
        .cout (c_dig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            nb_reg    <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        nb_reg   <= ~b;
                        carry    <= 1'b1;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (k == LAST_DIGIT) begin
                        diff      <= {s_dig[1:0], acc};
                        carry     <= s_dig[2];
                        borrow    <= ~s_dig[2];
                        // b[31] is the complement of the latched ~b MSB
                        overflow  <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                                     (s_dig[1] != a_reg[WIDTH-1]);
                        k         <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc   <= {s_dig, acc[WIDTH-3:3]};
                        carry <= c_dig;
                        k     <= k + digit_idx_t'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_digit_serial.sv
module tb_sub32_digit_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int last_acc = -1;

    sub32_digit_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic logic [33:0] ref_sub(input logic [31:0] ra, input logic [31:0] rb);
        longint sd;
        logic   ovf;
        logic   brw;
        sd  = longint'($signed(ra)) - longint'($signed(rb));
        ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        brw = (ra < rb);
        return {ovf, brw, ra - rb};
    endfunction

    // One full transaction. Called at a negedge; returns at a negedge after the transfer.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input int stall);
        int          wait_n;
        int          lat;
        logic [33:0] exp_r;
        logic [31:0] d_hold;
        exp_r  = ref_sub(oa, ob);
        wait_n = 0;
        while (!in_ready && wait_n < 30) begin
            @(negedge clk);
            wait_n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = oa;
        b         = ob;
        out_ready = (stall == 0);
        @(negedge clk);
        if (last_acc >= 0) chk("interval_ge13", 32'(cyc - last_acc >= 13), 32'd1);
        last_acc = cyc;
        chk("accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid = 1'($urandom);
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd11);
        chk("diff", diff, exp_r[31:0]);
        chk("borrow", 32'(borrow), 32'(exp_r[32]));
        chk("overflow", 32'(overflow), 32'(exp_r[33]));
        d_hold = diff;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a        = $urandom;
            b        = $urandom;
            @(negedge clk);
        end
        if (stall > 0) begin
            chk("stall_diff", diff, d_hold);
            chk("stall_flags", {30'd0, borrow, overflow}, {30'd0, exp_r[32], exp_r[33]});
            chk("stall_valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_xfer", {30'd0, out_valid, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", {diff[29:0], borrow, overflow} | {31'd0, diff[31] | diff[30]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd5, 32'd3, 0);
        run_op(32'd0, 32'd1, 0);
        run_op(32'h8000_0000, 32'd1, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 20);

        // Reset in the middle of RUN: operation dropped, no result.
        in_valid = 1'b1;
        a        = 32'd99;
        b        = 32'd1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        seen_valid = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1;
        end
        chk("midrst_no_result", 32'(seen_valid), 32'd0);
        last_acc  = -1;
        out_ready = 1'b0;
        run_op(32'd10, 32'd10, 0);

        for (int n = 0; n < 2500; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            int          st;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = {1'b1, 31'(ra)};
                default: ;
            endcase
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_op(ra, rb, st);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
